// File: rtl/isr_job_queue_if.sv
// rtl/isr_job_queue_if.sv - request, engine and response signals of the isqrt job queue
interface isr_job_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_value;
    logic [TAG_W-1:0] req_tag;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             isr_start;
    logic [63:0]      isr_value;
    logic [31:0]      isr_result;
    logic             isr_done;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_timeout;

    modport slave (
        input  req_valid, req_value, req_tag, isr_result, isr_done, resp_ready,
        output req_ready, count, busy, isr_start, isr_value,
               resp_valid, resp_result, resp_tag, resp_timeout
    );

    modport master (
        output req_valid, req_value, req_tag, isr_result, isr_done, resp_ready,
        input  req_ready, count, busy, isr_start, isr_value,
               resp_valid, resp_result, resp_tag, resp_timeout
    );
endinterface

// File: rtl/isr_job_queue.sv
// rtl/isr_job_queue.sv - tagged request FIFO feeding the isqrt engine one job at a time
module isr_job_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 600
) (
    input  logic          clock,
    input  logic          reset,
    isr_job_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_t;

    logic [63:0]      r_fifo_value [DEPTH];
    logic [TAG_W-1:0] r_fifo_tag   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    logic             r_busy;
    logic             r_isr_start;
    logic [63:0]      r_isr_value;
    logic [TAG_W-1:0] r_job_tag;
    logic [TMR_W-1:0] r_timer;
    logic             r_resp_valid;
    logic [31:0]      r_resp_result;
    logic [TAG_W-1:0] r_resp_tag;
    logic             r_resp_timeout;

    logic w_req_ready;
    logic w_push;
    logic w_pop;

    assign w_req_ready = (r_count != CNT_W'(DEPTH));
    assign w_push      = bus.req_valid && w_req_ready;
    // The head leaves the FIFO on the edge into LAUNCH so isr_value is already registered there.
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_value[r_wr_ptr] <= bus.req_value;
            r_fifo_tag[r_wr_ptr]   <= bus.req_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_isr_start    <= 1'b0;
            r_isr_value    <= '0;
            r_job_tag      <= '0;
            r_timer        <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_result  <= '0;
            r_resp_tag     <= '0;
            r_resp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= S_LAUNCH;
                        r_busy      <= 1'b1;
                        r_isr_start <= 1'b1;
                        r_isr_value <= r_fifo_value[r_rd_ptr];
                        r_job_tag   <= r_fifo_tag[r_rd_ptr];
                    end
                end
                S_LAUNCH: begin
                    r_isr_start <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= S_BUSY;
                end
                S_BUSY: begin
                    if (r_timer != TMR_W'(TIMEOUT)) r_timer <= r_timer + TMR_W'(1);
                    // A done arriving in the last allowed cycle still wins over the timeout.
                    if (bus.isr_done) begin
                        r_resp_valid   <= 1'b1;
                        r_resp_result  <= bus.isr_result;
                        r_resp_tag     <= r_job_tag;
                        r_resp_timeout <= 1'b0;
                        r_state        <= S_RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_resp_valid   <= 1'b1;
                        r_resp_result  <= '0;
                        r_resp_tag     <= r_job_tag;
                        r_resp_timeout <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.count        = r_count;
    assign bus.busy         = r_busy;
    assign bus.isr_start    = r_isr_start;
    assign bus.isr_value    = r_isr_value;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_result  = r_resp_result;
    assign bus.resp_tag     = r_resp_tag;
    assign bus.resp_timeout = r_resp_timeout;
endmodule

// File: tb/tb_isr_job_queue.sv
// tb/tb_isr_job_queue.sv - self-checking bench for isr_job_queue with a behavioural engine model
module tb_isr_job_queue;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 600;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    isr_job_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) ifc ();

    isr_job_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             to;
    } exp_t;

    exp_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    longint      t_start  = 0;
    longint      t_resp   = 0;
    logic [31:0] last_res;

    bit          eng_stall  = 1'b0;
    bit          eng_active = 1'b0;
    bit          eng_force  = 1'b0;
    bit          eng_rand   = 1'b0;
    int          eng_latency = 10;
    int          eng_cnt    = 0;
    logic [63:0] eng_val    = '0;
    int          n_starts   = 0;
    int          n_glitch   = 0;

    function automatic logic [31:0] isqrt(logic [63:0] v);
        logic [31:0] r = '0;
        logic [63:0] t;
        for (int b = 31; b >= 0; b--) begin
            t = {32'b0, r | (32'h1 << b)};
            if (t * t <= v) r = r | (32'h1 << b);
        end
        return r;
    endfunction

    always @(posedge clock) cyc++;

    // Engine model: captures the value on start, answers after a latency unless stalled.
    always @(negedge clock) begin
        ifc.isr_done = 1'b0;
        if (eng_force) begin
            ifc.isr_done   = 1'b1;
            ifc.isr_result = 32'h0000_0123;
            eng_force      = 1'b0;
        end else if (ifc.isr_start) begin
            n_starts++;
            t_start    = cyc;
            eng_val    = ifc.isr_value;
            eng_cnt    = eng_rand ? int'($urandom_range(1, 40)) : eng_latency;
            eng_active = 1'b1;
        end else if (eng_active) begin
            if (ifc.busy && ifc.isr_value !== eng_val) n_glitch++;
            if (!eng_stall) begin
                if (eng_cnt <= 1) begin
                    ifc.isr_done   = 1'b1;
                    ifc.isr_result = isqrt(eng_val);
                    eng_active     = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [63:0] v, logic [TAG_W-1:0] t, bit to);
        int n = 0;
        @(negedge clock);
        ifc.req_valid = 1'b1;
        ifc.req_value = v;
        ifc.req_tag   = t;
        while (!ifc.req_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) chk("push_wait_ready", ifc.req_ready, 1);
        @(posedge clock);
        exp_q.push_back('{to ? 32'h0 : isqrt(v), t, to});
        #1 ifc.req_valid = 1'b0;
    endtask

    task automatic check_resp(string tag);
        exp_t e;
        chk({tag, "_valid"}, ifc.resp_valid, 1);
        chk({tag, "_expected_pending"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, ifc.resp_result, e.res);
            chk({tag, "_tag"}, ifc.resp_tag, e.tag);
            chk({tag, "_timeout"}, ifc.resp_timeout, e.to);
        end
        last_res = ifc.resp_result;
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        while (!ifc.resp_valid && n < 1000) begin
            @(negedge clock);
            n++;
        end
        t_resp = cyc;
    endtask

    task automatic get_resp(string tag);
        @(negedge clock);
        ifc.resp_ready = 1'b1;
        wait_resp_valid();
        check_resp(tag);
        @(negedge clock);
        chk({tag, "_valid_drop"}, ifc.resp_valid, 0);
        ifc.resp_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        int          n_bad;
        int          k;
        bit          acc;
        logic [63:0] v;
        logic [31:0] snap_res;
        logic [TAG_W-1:0] snap_tag;
        logic        snap_to;

        reset          = 1'b1;
        ifc.req_valid  = 1'b0;
        ifc.req_value  = '0;
        ifc.req_tag    = '0;
        ifc.resp_ready = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_req_ready", ifc.req_ready, 1);
        chk("rst_count", ifc.count, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_isr_start", ifc.isr_start, 0);
        chk("rst_isr_value", ifc.isr_value, 0);
        chk("rst_resp_valid", ifc.resp_valid, 0);
        chk("rst_resp_result", ifc.resp_result, 0);
        chk("rst_resp_tag", ifc.resp_tag, 0);
        chk("rst_resp_timeout", ifc.resp_timeout, 0);
        reset = 1'b0;

        // Single job: value 100, answer 10 after 40 engine cycles.
        eng_latency = 40;
        s0 = n_starts;
        push(64'd100, 4'd3, 1'b0);
        get_resp("t1");
        chk("t1_start_pulses", n_starts - s0, 1);
        chk("t1_isr_value", eng_val, 64'd100);
        chk("t1_latency", t_resp - t_start, 41);

        // Stalled engine: the FIFO fills to DEPTH behind the in-flight job.
        eng_stall   = 1'b1;
        eng_latency = 15;
        s0 = n_starts;
        for (int i = 0; i < 5; i++) push({$urandom, $urandom}, TAG_W'(i), 1'b0);
        chk("t2_count_full", ifc.count, DEPTH);
        chk("t2_req_ready_low", ifc.req_ready, 0);
        @(negedge clock);
        ifc.req_valid = 1'b1;
        ifc.req_value = {$urandom, $urandom};
        ifc.req_tag   = TAG_W'(5);
        n_bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (ifc.req_ready !== 1'b0) n_bad++;
        end
        ifc.req_valid = 1'b0;
        chk("t2_sixth_blocked", n_bad, 0);
        chk("t2_count_held", ifc.count, DEPTH);
        chk("t2_one_launch", n_starts - s0, 1);
        eng_stall = 1'b0;
        for (int i = 0; i < 5; i++) get_resp("t2");

        // Consumer back-pressure: response held, no launch, FIFO still accepts.
        eng_rand = 1'b1;
        push({$urandom, $urandom}, TAG_W'(7), 1'b0);
        wait_resp_valid();
        chk("t3_resp_valid", ifc.resp_valid, 1);
        snap_res = ifc.resp_result;
        snap_tag = ifc.resp_tag;
        snap_to  = ifc.resp_timeout;
        s0 = n_starts;
        n_bad = 0;
        k = 8;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (!ifc.resp_valid || ifc.resp_result !== snap_res ||
                ifc.resp_tag !== snap_tag || ifc.resp_timeout !== snap_to) n_bad++;
            if (ifc.req_ready) begin
                v = {$urandom, $urandom};
                ifc.req_valid = 1'b1;
                ifc.req_value = v;
                ifc.req_tag   = TAG_W'(k);
                acc = 1'b1;
            end else begin
                ifc.req_valid = 1'b0;
                acc = 1'b0;
            end
            @(posedge clock);
            if (acc) begin
                exp_q.push_back('{isqrt(v), TAG_W'(k), 1'b0});
                k++;
            end
        end
        @(negedge clock);
        ifc.req_valid = 1'b0;
        chk("t3_resp_stable", n_bad, 0);
        chk("t3_no_launch", n_starts - s0, 0);
        chk("t3_count_full", ifc.count, DEPTH);
        chk("t3_req_ready_low", ifc.req_ready, 0);
        for (int i = 0; i < 5; i++) get_resp("t3");

        // Engine never answers: timeout after TIMEOUT busy cycles, then a normal job.
        eng_rand  = 1'b0;
        eng_stall = 1'b1;
        push({$urandom, $urandom}, TAG_W'(9), 1'b1);
        get_resp("t4");
        chk("t4_timeout_latency", t_resp - t_start, TIMEOUT + 1);
        eng_stall   = 1'b0;
        eng_latency = 12;
        push({32'h0, $urandom}, TAG_W'(10), 1'b0);
        get_resp("t4_next");
        chk("t4_next_latency", t_resp - t_start, 13);

        // Reset while busy; the engine's late done must be ignored.
        eng_latency = 30;
        push({$urandom, $urandom}, TAG_W'(11), 1'b0);
        repeat (12) @(negedge clock);
        chk("t5_busy_before_reset", ifc.busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        chk("t5_resp_valid", ifc.resp_valid, 0);
        chk("t5_count", ifc.count, 0);
        chk("t5_req_ready", ifc.req_ready, 1);
        chk("t5_busy", ifc.busy, 0);
        n_bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (ifc.resp_valid || ifc.busy) n_bad++;
        end
        chk("t5_late_done_ignored", n_bad, 0);

        // Stray done in IDLE, maximum radicand, push and pop in the same cycle.
        eng_force = 1'b1;
        repeat (3) @(negedge clock);
        chk("t6_idle_done_busy", ifc.busy, 0);
        chk("t6_idle_done_resp", ifc.resp_valid, 0);
        eng_latency = 20;
        push(64'hFFFF_FFFF_FFFF_FFFF, TAG_W'(12), 1'b0);
        get_resp("t6_max");
        chk("t6_max_result", last_res, 32'hFFFF_FFFF);

        eng_stall = 1'b1;
        for (int i = 1; i <= 3; i++) push({$urandom, $urandom}, TAG_W'(i), 1'b0);
        chk("t6_count_two", ifc.count, 2);
        eng_stall = 1'b0;
        @(negedge clock);
        wait_resp_valid();
        check_resp("t6_a");
        ifc.resp_ready = 1'b1;
        @(negedge clock);
        ifc.resp_ready = 1'b0;
        chk("t6_idle_busy", ifc.busy, 0);
        chk("t6_idle_count", ifc.count, 2);
        v = {$urandom, $urandom};
        ifc.req_valid = 1'b1;
        ifc.req_value = v;
        ifc.req_tag   = TAG_W'(4);
        @(posedge clock);
        exp_q.push_back('{isqrt(v), TAG_W'(4), 1'b0});
        @(negedge clock);
        ifc.req_valid = 1'b0;
        chk("t6_pushpop_count", ifc.count, 2);
        chk("t6_pushpop_busy", ifc.busy, 1);
        for (int i = 0; i < 3; i++) get_resp("t6_b");

        // Random jobs with random latencies and a mix of small and full-width values.
        eng_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) v = {32'h0, 22'h0, 10'($urandom_range(0, 1000))};
            else v = {$urandom, $urandom};
            push(v, TAG_W'($urandom), 1'b0);
            get_resp("rand");
        end

        chk("isr_value_stable", n_glitch, 0);
        chk("all_responses_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
